ext_mem_bridge: RTL and testbench

- Parametrised byte-serial external memory master for an 8-bit bidirectional pad bus with a 4-phase req/ack handshake.
- Takes word-level read/write burst commands from the CPU core. Sends the address once, low byte first, then moves LEN+1 words of DATA_BYTES each.
- Generalises the earlier fixed 16-bit-address, 8-bit-data, single-beat port: adds variable address and data width, bursts, an ack synchroniser and an optional timeout.

---
 rtl/ext_mem_pkg.sv | 23 ++
 rtl/ext_mem_hs.sv | 85 ++++++++
 rtl/ext_mem_bridge.sv | 191 +++++++++++++++++++
 tb/tb_ext_mem_bridge.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the byte-serial external memory bridge.
package ext_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        PH_WAIT_LOW = 1'b0,
        PH_REQ      = 1'b1
    } phase_t;

    localparam logic [7:0] OE_ALL  = 8'hFF;
    localparam logic [7:0] OE_NONE = 8'h00;

    // Index of the final byte of an n-byte field (n is 1..4).
    function automatic logic [1:0] last_idx(input int unsigned n);
        return 2'(n - 1);
    endfunction

endpackage

// File: rtl/ext_mem_hs.sv
// Per-byte 4-phase req/ack handshake: ack synchroniser, request phase
// machine and, with EXT_MEM_TIMEOUT_EN defined, a stall timeout.
//
// state       | meaning
// PH_WAIT_LOW | waiting for ack_s low before raising req
// PH_REQ      | req high, waiting for ack_s high
module ext_mem_hs
    import ext_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic valid,
    input  logic pad_ack,
    output logic pad_req,
    output logic byte_done,
    output logic timeout
);

    logic   ack_meta;
    logic   ack_s;
    phase_t phase;

    // Two-flop synchroniser; the device ack is fully asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= pad_ack;
            ack_s    <= ack_meta;
        end
    end

    // The byte completes in the cycle ack_s is seen high while req is up.
    assign byte_done = valid && (phase == PH_REQ) && ack_s;

    // Request phase machine; idles with req low whenever no byte is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= PH_WAIT_LOW;
            pad_req <= 1'b0;
        end else if (start || !valid || timeout) begin
            phase   <= PH_WAIT_LOW;
            pad_req <= 1'b0;
        end else if (phase == PH_WAIT_LOW) begin
            if (!ack_s) begin
                phase   <= PH_REQ;
                pad_req <= 1'b1;
            end
        end else if (ack_s) begin
            phase   <= PH_WAIT_LOW;
            pad_req <= 1'b0;
        end
    end

`ifdef EXT_MEM_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic             phase_change;
    logic [TMR_W-1:0] tmr;

    assign phase_change = valid && (((phase == PH_WAIT_LOW) && !ack_s) || byte_done);
    assign timeout      = valid && !phase_change && (tmr == '0);

    // Down-counter reloaded on every phase change; terminal count aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (start || !valid || phase_change) begin
            tmr <= TMR_W'(TIMEOUT - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

endmodule

// File: rtl/ext_mem_bridge.sv
// Byte-serial external memory master: word-level read/write bursts over an
// 8-bit bidirectional pad bus. Address goes out once, low byte first; the
// device auto-increments for the remaining words of a burst.
// Optional EXT_MEM_TIMEOUT_EN: abort a stalled handshake and set err.
//
// state   | meaning
// ST_IDLE | ready for a command, pads tri-stated
// ST_ADDR | driving address bytes, little-endian
// ST_DATA | moving data bytes (driven on write, sampled on read)
module ext_mem_bridge
    import ext_mem_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 1,
    parameter int LEN_W      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [8*ADDR_BYTES-1:0] cmd_addr,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    wr_ready,
    output logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    done,
    output logic                    busy,
    output logic                    err,
    output logic [7:0]              pad_out,
    output logic [7:0]              pad_oe,
    input  logic [7:0]              pad_in,
    output logic                    pad_req,
    input  logic                    pad_ack,
    output logic                    pad_rd,
    output logic                    pad_wr
);

    localparam logic [1:0] ADDR_LAST = last_idx(ADDR_BYTES);
    localparam logic [1:0] DATA_LAST = last_idx(DATA_BYTES);

    state_t                  state;
    logic [1:0]              idx;
    logic [LEN_W-1:0]        word_cnt;
    logic [LEN_W-1:0]        len_q;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic                    write_q;
    logic                    accept;
    logic                    byte_done;
    logic                    hs_timeout;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    ext_mem_hs #(
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .valid     (busy),
        .pad_ack   (pad_ack),
        .pad_req   (pad_req),
        .byte_done (byte_done),
        .timeout   (hs_timeout)
    );

    // Pad drive derives from registered state, so it is stable across each
    // req high period and tri-states together with an async reset.
    always_comb begin
        pad_out = 8'h00;
        pad_oe  = OE_NONE;
        case (state)
            ST_ADDR: begin
                pad_oe = OE_ALL;
                for (int b = 0; b < ADDR_BYTES; b++) begin
                    if (idx == 2'(b)) pad_out = addr_q[b*8 +: 8];
                end
            end
            ST_DATA: begin
                if (write_q) begin
                    pad_oe = OE_ALL;
                    for (int b = 0; b < DATA_BYTES; b++) begin
                        if (idx == 2'(b)) pad_out = wr_data[b*8 +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    // Command sequencing: address phase, then LEN+1 data words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            word_cnt <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            done     <= 1'b0;
            pad_rd   <= 1'b0;
            pad_wr   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state    <= ST_ADDR;
                        idx      <= 2'd0;
                        word_cnt <= '0;
                        len_q    <= cmd_len;
                        addr_q   <= cmd_addr;
                        write_q  <= cmd_write;
                        pad_rd   <= !cmd_write;
                        pad_wr   <= cmd_write;
                    end
                end
                ST_ADDR: begin
                    if (hs_timeout) begin
                        state  <= ST_IDLE;
                        idx    <= 2'd0;
                        pad_rd <= 1'b0;
                        pad_wr <= 1'b0;
                    end else if (byte_done) begin
                        if (idx == ADDR_LAST) begin
                            idx   <= 2'd0;
                            state <= ST_DATA;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (hs_timeout) begin
                        state  <= ST_IDLE;
                        idx    <= 2'd0;
                        pad_rd <= 1'b0;
                        pad_wr <= 1'b0;
                    end else if (byte_done) begin
                        if (!write_q) begin
                            for (int b = 0; b < DATA_BYTES; b++) begin
                                if (idx == 2'(b)) rd_data[b*8 +: 8] <= pad_in;
                            end
                        end
                        if (idx == DATA_LAST) begin
                            idx      <= 2'd0;
                            wr_ready <= write_q;
                            rd_valid <= !write_q;
                            if (word_cnt == len_q) begin
                                done   <= 1'b1;
                                state  <= ST_IDLE;
                                pad_rd <= 1'b0;
                                pad_wr <= 1'b0;
                            end else begin
                                word_cnt <= word_cnt + LEN_W'(1);
                            end
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef EXT_MEM_TIMEOUT_EN
    // Sticky abort flag, cleared when the next command is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (hs_timeout) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Directed bench for ext_mem_bridge. Instance a: 2 address bytes, 1 data
// byte. Instance b: 2 address bytes, 2 data bytes. A shared device model
// answers whichever instance sel points at.
`timescale 1ns/1ps
module tb_ext_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        cmd_valid;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [15:0] wr_data;
    logic [7:0]  pad_in;
    logic        pad_ack;

    logic        cmd_ready_a, wr_ready_a, rd_valid_a, done_a, busy_a, err_a;
    logic        pad_req_a, pad_rd_a, pad_wr_a;
    logic [7:0]  rd_data_a, pad_out_a, pad_oe_a;
    logic        cmd_ready_b, wr_ready_b, rd_valid_b, done_b, busy_b, err_b;
    logic        pad_req_b, pad_rd_b, pad_wr_b;
    logic [15:0] rd_data_b;
    logic [7:0]  pad_out_b, pad_oe_b;

    ext_mem_bridge #(.ADDR_BYTES(2), .DATA_BYTES(1), .LEN_W(4), .TIMEOUT(10)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready_a),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data[7:0]), .wr_ready(wr_ready_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .done(done_a), .busy(busy_a), .err(err_a),
        .pad_out(pad_out_a), .pad_oe(pad_oe_a), .pad_in(pad_in), .pad_req(pad_req_a),
        .pad_ack(pad_ack), .pad_rd(pad_rd_a), .pad_wr(pad_wr_a)
    );

    ext_mem_bridge #(.ADDR_BYTES(2), .DATA_BYTES(2), .LEN_W(4), .TIMEOUT(10)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready_b),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_ready(wr_ready_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .done(done_b), .busy(busy_b), .err(err_b),
        .pad_out(pad_out_b), .pad_oe(pad_oe_b), .pad_in(pad_in), .pad_req(pad_req_b),
        .pad_ack(pad_ack), .pad_rd(pad_rd_b), .pad_wr(pad_wr_b)
    );

    logic        cmd_ready_m, wr_ready_m, rd_valid_m, done_m, busy_m, err_m;
    logic        pad_req_m, pad_rd_m, pad_wr_m;
    logic [15:0] rd_data_m;
    logic [7:0]  pad_out_m, pad_oe_m;

    assign cmd_ready_m = sel ? cmd_ready_b : cmd_ready_a;
    assign wr_ready_m  = sel ? wr_ready_b  : wr_ready_a;
    assign rd_valid_m  = sel ? rd_valid_b  : rd_valid_a;
    assign done_m      = sel ? done_b      : done_a;
    assign busy_m      = sel ? busy_b      : busy_a;
    assign err_m       = sel ? err_b       : err_a;
    assign pad_req_m   = sel ? pad_req_b   : pad_req_a;
    assign pad_rd_m    = sel ? pad_rd_b    : pad_rd_a;
    assign pad_wr_m    = sel ? pad_wr_b    : pad_wr_a;
    assign rd_data_m   = sel ? rd_data_b   : {8'h00, rd_data_a};
    assign pad_out_m   = sel ? pad_out_b   : pad_out_a;
    assign pad_oe_m    = sel ? pad_oe_b    : pad_oe_a;

    // Device model: acks ack_dly cycles after seeing req, logs the pad state.
    logic       dev_en;
    logic       dev_ack;
    logic       force_en;
    logic       force_val;
    int         ack_dly;
    int         dev_cnt;
    int         rd_ptr;
    logic [7:0] rd_bytes[$];
    logic [7:0] log_out[$];
    logic [7:0] log_oe[$];
    logic       log_rd[$];
    logic       log_wr[$];

    assign pad_ack = force_en ? force_val : dev_ack;

    initial begin
        dev_ack = 1'b0;
        pad_in  = 8'h00;
        dev_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!dev_en) begin
                dev_cnt = 0;
            end else if (!dev_ack && pad_req_m) begin
                dev_cnt++;
                if (dev_cnt >= ack_dly) begin
                    log_out.push_back(pad_out_m);
                    log_oe.push_back(pad_oe_m);
                    log_rd.push_back(pad_rd_m);
                    log_wr.push_back(pad_wr_m);
                    pad_in  = (rd_ptr < rd_bytes.size()) ? rd_bytes[rd_ptr] : 8'h00;
                    rd_ptr++;
                    dev_ack = 1'b1;
                    dev_cnt = 0;
                end
            end else if (dev_ack && !pad_req_m) begin
                dev_cnt++;
                if (dev_cnt >= ack_dly) begin
                    dev_ack = 1'b0;
                    dev_cnt = 0;
                end
            end else begin
                dev_cnt = 0;
            end
        end
    end

    // Output monitor on the falling edge.
    int          wr_n, done_n, type_gap;
    logic        done_on_word;
    logic [15:0] rd_q[$];

    initial begin
        wr_n = 0; done_n = 0; type_gap = 0; done_on_word = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_valid_m) rd_q.push_back(rd_data_m);
            if (wr_ready_m) wr_n++;
            if (done_m) begin
                done_n++;
                done_on_word = rd_valid_m || wr_ready_m;
            end
            if (busy_m && !(pad_rd_m ^ pad_wr_m)) type_gap++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic clear_logs();
        log_out.delete(); log_oe.delete(); log_rd.delete(); log_wr.delete();
        rd_bytes.delete(); rd_q.delete();
        rd_ptr = 0; wr_n = 0; done_n = 0; type_gap = 0; done_on_word = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [3:0] len);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int start_n;
        bit seen;
        start_n = done_n;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (done_n > start_n) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done: no done within %0d cycles (got none, required 1)", max_cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready_a, busy_a, pad_req_a, pad_rd_a, pad_wr_a, done_a, err_a, rd_valid_a, wr_ready_a}
                !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b required 100000000",
                {cmd_ready_a, busy_a, pad_req_a, pad_rd_a, pad_wr_a, done_a, err_a, rd_valid_a, wr_ready_a});
        end
        checks++;
        if ({pad_out_a, pad_oe_a, rd_data_a} !== 24'h0) begin
            errors++;
            $display("FAIL reset_pads_a: got %h required 000000", {pad_out_a, pad_oe_a, rd_data_a});
        end
        checks++;
        if ({cmd_ready_b, busy_b, pad_req_b, pad_oe_b, rd_data_b} !== {3'b100, 24'h0}) begin
            errors++;
            $display("FAIL reset_b: got %h required %h",
                {cmd_ready_b, busy_b, pad_req_b, pad_oe_b, rd_data_b}, {3'b100, 24'h0});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        logic [7:0] exp_out[3];
        sel = 1'b0; ack_dly = 3; clear_logs();
        exp_out[0] = 8'hFE; exp_out[1] = 8'hCA; exp_out[2] = 8'h5A;
        wr_data = 16'h005A;
        issue(1'b1, 16'hCAFE, 4'd0);
        wait_done(300);
        checks++;
        if (log_out.size() != 3) begin
            errors++;
            $display("FAIL write_nbytes: got %0d required 3", log_out.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({log_out[i], log_oe[i], log_wr[i], log_rd[i]} !== {exp_out[i], 8'hFF, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL write_byte%0d: got out/oe/wr/rd %h/%h/%b/%b required %h/ff/1/0",
                    i, log_out[i], log_oe[i], log_wr[i], log_rd[i], exp_out[i]);
            end
        end
        checks++;
        if ({wr_n, done_n, done_on_word, type_gap} !== {32'd1, 32'd1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL write_pulses: got wr_ready %0d done %0d on_word %b type_gap %0d required 1 1 1 0",
                wr_n, done_n, done_on_word, type_gap);
        end
        checks++;
        if ({cmd_ready_m, busy_m, pad_wr_m, pad_oe_m} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL write_idle: got ready/busy/wr/oe %b%b%b/%h required 100/00",
                cmd_ready_m, busy_m, pad_wr_m, pad_oe_m);
        end
    endtask

    task automatic test_read_burst();
        logic [15:0] exp_w[4];
        sel = 1'b1; ack_dly = 2; clear_logs();
        exp_w[0] = 16'h1234; exp_w[1] = 16'h5678; exp_w[2] = 16'h9ABC; exp_w[3] = 16'hDEF0;
        rd_bytes.push_back(8'h34); rd_bytes.push_back(8'h12);
        rd_bytes.push_back(8'h78); rd_bytes.push_back(8'h56);
        rd_bytes.push_back(8'hBC); rd_bytes.push_back(8'h9A);
        rd_bytes.push_back(8'hF0); rd_bytes.push_back(8'hDE);
        rd_ptr = -2;
        issue(1'b0, 16'h0100, 4'd3);
        wait_done(600);
        checks++;
        if (rd_q.size() != 4) begin
            errors++;
            $display("FAIL read_nwords: got %0d required 4", rd_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_q[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL read_word%0d: got %h required %h", i, rd_q[i], exp_w[i]);
            end
        end
        checks++;
        if (log_out.size() != 10) begin
            errors++;
            $display("FAIL read_nbytes: got %0d required 10", log_out.size());
        end
        checks++;
        if ({log_out[0], log_oe[0], log_out[1], log_oe[1], log_rd[0], log_wr[0]} !== {32'h00FF01FF, 2'b10}) begin
            errors++;
            $display("FAIL read_addr: got %h%h%h%h rd/wr %b%b required 00ff01ff rd/wr 10",
                log_out[0], log_oe[0], log_out[1], log_oe[1], log_rd[0], log_wr[0]);
        end
        for (int i = 2; i < 10; i++) begin
            checks++;
            if ({log_oe[i], log_rd[i], log_wr[i]} !== {8'h00, 2'b10}) begin
                errors++;
                $display("FAIL read_data_oe%0d: got oe %h rd/wr %b%b required 00 10",
                    i, log_oe[i], log_rd[i], log_wr[i]);
            end
        end
        checks++;
        if ({wr_n, done_n, done_on_word, type_gap, rd_data_m} !== {32'd0, 32'd1, 1'b1, 32'd0, 16'hDEF0}) begin
            errors++;
            $display("FAIL read_pulses: got wr %0d done %0d on_word %b gap %0d rd_data %h required 0 1 1 0 def0",
                wr_n, done_n, done_on_word, type_gap, rd_data_m);
        end
    endtask

    task automatic test_ack_high();
        int early;
        sel = 1'b0; ack_dly = 2; clear_logs();
        dev_en = 1'b0; force_en = 1'b1; force_val = 1'b1;
        repeat (4) @(posedge clk);
        wr_data = 16'h0077;
        issue(1'b1, 16'h0011, 4'd0);
        early = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (pad_req_m) early++;
        end
        force_val = 1'b0;
        @(posedge clk); #1;
        if (pad_req_m) early++;
        @(posedge clk); #1;
        if (pad_req_m) early++;
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL ack_high_req_early: got %0d cycles with req high required 0", early);
        end
        @(posedge clk); #1;
        checks++;
        if (pad_req_m !== 1'b1) begin
            errors++;
            $display("FAIL ack_high_req_rise: got req %b required 1", pad_req_m);
        end
        force_en = 1'b0; dev_en = 1'b1;
        wait_done(300);
        checks++;
        if ({log_out[0], log_out[2], 8'(log_out.size()), 8'(done_n)} !== 32'h11770301) begin
            errors++;
            $display("FAIL ack_high_xfer: got %h %h n=%0d done=%0d required 11 77 n=3 done=1",
                log_out[0], log_out[2], log_out.size(), done_n);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        logic [7:0] exp_out[3];
        sel = 1'b0; ack_dly = 2; clear_logs();
        wr_data = 16'h0099;
        issue(1'b1, 16'h1234, 4'd0);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (log_out.size() == 1 && pad_req_m) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: got no req on 2nd address byte required req high");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({pad_req_m, pad_rd_m, pad_wr_m, busy_m, cmd_ready_m, done_m, pad_oe_m, pad_out_m}
                !== {6'b000010, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got req/rd/wr/busy/ready/done %b%b%b%b%b%b oe %h out %h required 000010 00 00",
                pad_req_m, pad_rd_m, pad_wr_m, busy_m, cmd_ready_m, done_m, pad_oe_m, pad_out_m);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL reset_mid_done: got %0d done pulses required 0", done_n);
        end
        clear_logs();
        exp_out[0] = 8'hEF; exp_out[1] = 8'hBE; exp_out[2] = 8'h3C;
        wr_data = 16'h003C;
        issue(1'b1, 16'hBEEF, 4'd0);
        wait_done(300);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_out[i] !== exp_out[i]) begin
                errors++;
                $display("FAIL reset_mid_retry%0d: got %h required %h", i, log_out[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] exp_out[3];
        sel = 1'b0; ack_dly = 2; clear_logs();
        exp_out[0] = 8'h66; exp_out[1] = 8'h55; exp_out[2] = 8'h42;
        wr_data = 16'h0042;
        issue(1'b1, 16'h5566, 4'd0);
        repeat (5) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'hAAAA; cmd_len = 4'd2;
        checks++;
        if (cmd_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: got cmd_ready %b required 0", cmd_ready_m);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(300);
        repeat (30) @(negedge clk);
        checks++;
        if ({8'(log_out.size()), 8'(done_n), busy_m} !== {8'd3, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL busy_ignored: got bytes %0d done %0d busy %b required 3 1 0",
                log_out.size(), done_n, busy_m);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_out[i] !== exp_out[i]) begin
                errors++;
                $display("FAIL busy_byte%0d: got %h required %h", i, log_out[i], exp_out[i]);
            end
        end
    endtask

`ifdef EXT_MEM_TIMEOUT_EN
    task automatic test_timeout();
        bit rose;
        sel = 1'b0; clear_logs();
        dev_en = 1'b0; force_en = 1'b1; force_val = 1'b0;
        wr_data = 16'h0001;
        issue(1'b1, 16'h0001, 4'd0);
        rose = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) begin
            @(posedge clk); #1;
            if (pad_req_m) rose = 1'b1;
        end
        checks++;
        if (!rose) begin
            errors++;
            $display("FAIL timeout_req: got no req required req high");
        end
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if ({err_m, busy_m} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early: got err/busy %b%b required 01", err_m, busy_m);
        end
        @(posedge clk); #1;
        checks++;
        if ({err_m, busy_m, pad_req_m, pad_oe_m, 8'(done_n)} !== {3'b100, 16'h0}) begin
            errors++;
            $display("FAIL timeout_abort: got err/busy/req %b%b%b oe %h done %0d required 100 00 0",
                err_m, busy_m, pad_req_m, pad_oe_m, done_n);
        end
        force_en = 1'b0; dev_en = 1'b1; ack_dly = 2;
        issue(1'b1, 16'h0002, 4'd0);
        checks++;
        if (err_m !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got err %b required 0", err_m);
        end
        wait_done(300);
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 4'd0;
        wr_data = 16'h0; dev_en = 1'b1; force_en = 1'b0; force_val = 1'b0;
        ack_dly = 3; rd_ptr = 0;
        test_reset();
        test_single_write();
        test_read_burst();
        test_ack_high();
        test_reset_mid();
        test_busy_ignore();
`ifdef EXT_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
